fba_accum: RTL and testbench

- Parametrised, handshaked streaming accumulator for CNN partial sums.
- Built on a generalised fixed-bounding approximate adder. The low APPROX_W bits use the bounding rule; the upper bits are added exactly.
- Packets of operands arrive over a valid/ready stream; the block returns one result per packet, plus a beat count and an overflow flag.
- A runtime mode bit selects exact or approximate arithmetic per packet, so accuracy/energy trade-offs can be evaluated in place.

---
 rtl/fba_accum.sv | 129 ++++++++++++
 tb/tb_fba_accum.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fba_accum.sv
// rtl/fba_accum.sv - handshaked packet accumulator on a fixed-bounding approximate adder
// Low APPROX_W bits use the bounding rule in approximate mode; upper bits always add exactly.
module fba_accum #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 24,
   parameter int APPROX_W = 8,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf,
   output logic [CNT_W-1:0]  out_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             mode_q;

   logic [ACC_W-1:0] opnd;
   logic [ACC_W:0]   exact_sum;
   logic [ACC_W-1:0] add_sum;
   logic             add_c;
   logic [ACC_W-1:0] next_acc;

   assign opnd      = ACC_W'(in_data);
   assign exact_sum = {1'b0, acc} + {1'b0, opnd};

   generate
      if (APPROX_W == 0) begin : g_exact
         assign add_sum = exact_sum[ACC_W-1:0];
         assign add_c   = exact_sum[ACC_W];
      end else begin : g_approx
         logic [ACC_W-APPROX_W:0] hi_sum;
         logic [APPROX_W-1:0]     lo_sum;
         logic                    found;

         assign hi_sum = {1'b0, acc[ACC_W-1:APPROX_W]} + {1'b0, opnd[ACC_W-1:APPROX_W]};

         // Scan down from the top of the low part; the first common set bit
         // (bit 0 excluded) forces itself and everything below it to ones.
         always_comb begin
            found  = 1'b0;
            lo_sum = '0;
            for (int i = APPROX_W - 1; i >= 0; i--) begin
               if (found) begin
                  lo_sum[i] = 1'b1;
               end else if (i > 0 && acc[i] && opnd[i]) begin
                  found     = 1'b1;
                  lo_sum[i] = 1'b1;
               end else if (i == 0) begin
                  lo_sum[i] = acc[0] | opnd[0];
               end else begin
                  lo_sum[i] = acc[i] ^ opnd[i];
               end
            end
         end

         assign add_sum = mode_q ? {hi_sum[ACC_W-APPROX_W-1:0], lo_sum} : exact_sum[ACC_W-1:0];
         assign add_c   = mode_q ? hi_sum[ACC_W-APPROX_W] : exact_sum[ACC_W];
      end
   endgenerate

   assign next_acc = (add_c && SATURATE) ? {ACC_W{1'b1}} : add_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc    <= opnd;
                  mode_q <= mode;
                  count  <= CNT_W'(1);
                  ovf    <= 1'b0;
                  state  <= in_last ? HOLD : ACC;
               end
            end
            ACC: begin
               if (in_valid) begin
                  acc <= next_acc;
                  if (add_c) begin
                     ovf <= 1'b1;
                  end
                  if (!(&count)) begin
                     count <= count + CNT_W'(1);
                  end
                  if (in_last) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
                  acc   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = !rst && (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_data  = acc;
   assign out_ovf   = ovf;
   assign out_count = count;

endmodule

// File: tb/tb_fba_accum.sv
// tb/tb_fba_accum.sv - scoreboard bench for fba_accum (24-bit default plus 16-bit saturating and wrapping instances)
module tb_fba_accum;

   typedef struct {
      logic [23:0] d;
      logic        o;
      logic [7:0]  c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_last, mode, out_ready;
   logic [15:0] in_data;
   logic        rdy0, rdy1, rdy2, v0, v1, v2, o0, o1, o2;
   logic [23:0] d0;
   logic [15:0] d1, d2;
   logic [7:0]  c0, c1, c2;

   int          vectors = 0;
   int          misc = 0;
   bit          bp_hold;
   exp_t        q[3][$];
   logic [15:0] pkt[$];

   always #5 clk = ~clk;

   fba_accum u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .in_last(in_last), .mode(mode), .out_valid(v0), .out_ready(out_ready),
      .out_data(d0), .out_ovf(o0), .out_count(c0));

   fba_accum #(.DATA_W(16), .ACC_W(16), .APPROX_W(8), .SATURATE(1'b1), .CNT_W(8)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .in_last(in_last), .mode(mode), .out_valid(v1), .out_ready(out_ready),
      .out_data(d1), .out_ovf(o1), .out_count(c1));

   fba_accum #(.DATA_W(16), .ACC_W(16), .APPROX_W(8), .SATURATE(1'b0), .CNT_W(8)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
      .in_last(in_last), .mode(mode), .out_valid(v2), .out_ready(out_ready),
      .out_data(d2), .out_ovf(o2), .out_count(c2));

   task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] want);
      vectors++;
      if (act !== want) begin
         misc++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // Reference adder: whole-number arithmetic on the bounding rule with an 8-bit low part.
   function automatic longint ref_add(input longint a, input longint b, input bit m,
                                      input int aw, input bit sat, inout bit ovf);
      longint full, hs, lo, r, msk;
      bit     c;
      int     top;
      full = (longint'(1) << aw) - 1;
      if (!m) begin
         r = a + b;
         c = ((r >> aw) & 1) != 0;
         r = r & full;
      end else begin
         hs  = (a >> 8) + (b >> 8);
         c   = ((hs >> (aw - 8)) & 1) != 0;
         top = -1;
         for (int i = 1; i < 8; i++)
            if ((((a & b) >> i) & 1) != 0) top = i;
         if (top >= 0) begin
            msk = (longint'(1) << (top + 1)) - 1;
            lo  = ((a ^ b) & ~msk & 255) | msk;
         end else begin
            lo = ((a ^ b) & 254) | ((a | b) & 1);
         end
         r = ((hs << 8) | lo) & full;
      end
      if (c) begin
         ovf = 1'b1;
         if (sat) r = full;
      end
      return r;
   endfunction

   task automatic pop_cmp(input int idx, input logic [23:0] d, input logic o, input logic [7:0] c);
      exp_t e;
      if (q[idx].size() == 0) begin
         vectors++;
         misc++;
         $display("FAIL unexpected_result dut%0d: got %h, want no result", idx, d);
      end else begin
         e = q[idx].pop_front();
         cmp($sformatf("dut%0d_data", idx), d, e.d);
         cmp($sformatf("dut%0d_ovf", idx), {23'd0, o}, {23'd0, e.o});
         cmp($sformatf("dut%0d_count", idx), {16'd0, c}, {16'd0, e.c});
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_ready) begin
         if (v0) pop_cmp(0, d0, o0, c0);
         if (v1) pop_cmp(1, {8'd0, d1}, o1, c1);
         if (v2) pop_cmp(2, {8'd0, d2}, o2, c2);
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (!bp_hold) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic beat(input logic [15:0] d, input bit l, input bit m);
      int g = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      mode     = m;
      while (!rdy0 && g < 200) begin
         @(posedge clk);
         #2;
         g++;
      end
      if (g >= 200) begin
         vectors++;
         misc++;
         $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, want 1", g);
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_last  = $urandom_range(0, 1);
      in_data  = 16'($urandom);
      mode     = $urandom_range(0, 1);
   endtask

   task automatic send_packet(input bit m, input bit gaps);
      exp_t   e;
      bit     ovf;
      longint a;
      int     n;
      n = pkt.size();
      for (int d = 0; d < 3; d++) begin
         a   = pkt[0];
         ovf = 1'b0;
         for (int k = 1; k < n; k++)
            a = ref_add(a, pkt[k], m, (d == 0) ? 24 : 16, d != 2, ovf);
         e.d = 24'(a);
         e.o = ovf;
         e.c = (n > 255) ? 8'hFF : 8'(n);
         q[d].push_back(e);
      end
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #2;
         end
         beat(pkt[k], k == n - 1, (k == 0) ? m : ~m);
      end
      cmp("latency_out_valid", {23'd0, v0}, 24'd1);
   endtask

   task automatic hold_begin(input bit m);
      bp_hold   = 1'b1;
      out_ready = 1'b0;
      send_packet(m, 1'b0);
   endtask

   task automatic hold_end();
      logic [23:0] held;
      held = d0;
      repeat (5) begin
         @(posedge clk);
         #2;
         cmp("bp_out_valid", {23'd0, v0}, 24'd1);
         cmp("bp_data_stable", d0, held);
         cmp("bp_in_ready", {23'd0, rdy0}, 24'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      cmp("release_out_valid", {23'd0, v0}, 24'd0);
      cmp("release_in_ready", {23'd0, rdy0}, 24'd1);
      bp_hold = 1'b0;
   endtask

   initial begin
      int guard;
      rst      = 1'b1;
      bp_hold  = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      mode     = 1'b0;
      #1;
      cmp("rst_in_ready", {23'd0, rdy0}, 24'd0);
      cmp("rst_out_valid", {23'd0, v0}, 24'd0);
      cmp("rst_out_data", d0, 24'd0);
      cmp("rst_out_count", {16'd0, c0}, 24'd0);
      cmp("rst_out_ovf", {23'd0, o0}, 24'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      cmp("post_rst_in_ready", {23'd0, rdy0}, 24'd1);

      pkt = '{16'h00C5, 16'h0087};
      hold_begin(1'b1);
      cmp("approx_c5_87", d0, 24'h0000FF);
      cmp("approx_c5_87_count", {16'd0, c0}, 24'd2);
      cmp("approx_c5_87_ovf", {23'd0, o0}, 24'd0);
      hold_end();

      hold_begin(1'b0);
      cmp("exact_c5_87", d0, 24'h00014C);
      hold_end();

      pkt = '{16'h0123, 16'h0045};
      hold_begin(1'b1);
      cmp("approx_123_45", d0, 24'h000167);
      hold_end();

      pkt = '{16'hFF00, 16'h0200, 16'h0001};
      hold_begin(1'b0);
      cmp("main_ff00_sum", d0, 24'h010101);
      cmp("sat16_data", {8'd0, d1}, 24'h00FFFF);
      cmp("sat16_ovf", {23'd0, o1}, 24'd1);
      cmp("wrap16_data", {8'd0, d2}, 24'h000101);
      cmp("wrap16_ovf", {23'd0, o2}, 24'd1);
      hold_end();

      pkt = '{16'h0F0F, 16'h0F0F};
      hold_begin(1'b1);
      cmp("mode_latched_first_beat", d0, 24'h001E0F);
      hold_end();

      pkt = '{16'h1234};
      hold_begin(1'b1);
      cmp("single_beat", d0, 24'h001234);
      cmp("single_beat_count", {16'd0, c0}, 24'd1);
      hold_end();

      for (int p = 0; p < 40; p++) begin
         pkt.delete();
         for (int k = 0; k < $urandom_range(1, 6); k++)
            pkt.push_back(($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                      : 16'($urandom));
         send_packet($urandom_range(0, 1), 1'b1);
      end

      pkt.delete();
      for (int k = 0; k < 260; k++)
         pkt.push_back(16'hFF00 | 16'($urandom_range(0, 255)));
      send_packet($urandom_range(0, 1), 1'b1);

      beat(16'h1111, 1'b0, 1'b1);
      beat(16'h2222, 1'b0, 1'b1);
      beat(16'h3333, 1'b0, 1'b1);
      in_valid = 1'b1;
      rst      = 1'b1;
      #1;
      cmp("midrst_in_ready", {23'd0, rdy0}, 24'd0);
      cmp("midrst_out_valid", {23'd0, v0}, 24'd0);
      cmp("midrst_out_data", d0, 24'd0);
      cmp("midrst_out_count", {16'd0, c0}, 24'd0);
      cmp("midrst_out_ovf", {23'd0, o0}, 24'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      cmp("midrst_release_in_ready", {23'd0, rdy0}, 24'd1);
      pkt = '{16'h0042, 16'h0001};
      send_packet(1'b0, 1'b0);

      guard = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      cmp("drain_q0", 24'(q[0].size()), 24'd0);
      cmp("drain_q1", 24'(q[1].size()), 24'd0);
      cmp("drain_q2", 24'(q[2].size()), 24'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule
